// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store sequencer between the core datapath and a
// word-aligned data-memory bus.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   mem_rd, mem_wr    load / store present from the decoder (store wins if both)
//   load_sz, store_sz access size codes from the decoder
//   addr, wdata       ALU byte address and rs2 store data
//   stall             holds PC and write-back while an access is in progress
//   rdata             registered, extended load result (held until next load)
//   done, err         one-cycle completion pulse; err qualifies it
//   bus_*             memory request side (req/ack handshake)
//   state_dbg         current FSM state encoding (IDLE=0, REQ=1, DONE=2)
//
// Bus handshake: bus_req rises in the first REQ cycle and stays high, with
// bus_addr/bus_we/bus_be/bus_wdata held constant, until the cycle in which
// bus_ack is sampled high (bus_rdata valid in that same cycle). The request
// then drops on the next cycle. bus_ack outside REQ is ignored.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  load_sz,
    input  logic [1:0]  store_sz,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_inc;
    logic        timeout_hit;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] lat_addr;
    logic        lat_we;
    logic [2:0]  lat_lsz;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;

    // Incoming request decode
    logic        req_any;
    logic        half_t;
    logic        word_t;
    logic        sz_illegal;
    logic        acc_ok;
    logic [1:0]  off;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;

    always_comb begin
        req_any    = mem_wr | mem_rd;
        off        = addr[1:0];
        half_t     = 1'b0;
        word_t     = 1'b0;
        sz_illegal = 1'b0;
        be_in      = 4'b1111;
        wdata_in   = wdata;
        if (mem_wr) begin
            case (store_sz)
                2'b00: begin
                    be_in    = 4'b0001 << off;
                    wdata_in = {4{wdata[7:0]}};
                end
                2'b01: begin
                    half_t   = 1'b1;
                    be_in    = 4'b0011 << off;
                    wdata_in = {2{wdata[15:0]}};
                end
                2'b10:   word_t     = 1'b1;
                default: sz_illegal = 1'b1;
            endcase
        end else begin
            case (load_sz)
                3'b000, 3'b011: ;
                3'b001, 3'b100: half_t = 1'b1;
                3'b010:         word_t = 1'b1;
                default:        sz_illegal = 1'b1;
            endcase
        end
        acc_ok = ~sz_illegal & ~((half_t & off[0]) | (word_t & (off != 2'b00)));
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_inc     = cnt_q + 8'd1;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: if (req_any) state_d = acc_ok ? REQ : DONE;
            REQ: begin
                // ack takes priority over a timeout landing in the same cycle
                if (bus_ack) begin
                    state_d = DONE;
                end else if (cnt_inc == TIMEOUT_LIM) begin
                    state_d     = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load lane extraction from the latched offset and size
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        case (lat_addr[1:0])
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lat_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lat_lsz)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b011:  ld_ext = {24'd0, ld_byte};
            3'b100:  ld_ext = {16'd0, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            lat_addr  <= 32'd0;
            lat_we    <= 1'b0;
            lat_lsz   <= 3'd0;
            lat_be    <= 4'd0;
            lat_wdata <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (req_any) begin
                        err_q <= ~acc_ok;
                        if (acc_ok) begin
                            lat_addr  <= addr;
                            lat_we    <= mem_wr;
                            lat_lsz   <= load_sz;
                            lat_be    <= be_in;
                            lat_wdata <= wdata_in;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_inc;
                    if (bus_ack && !lat_we) rdata_q <= ld_ext;
                    if (timeout_hit) err_q <= 1'b1;
                end
                default: cnt_q <= 8'd0;
            endcase
        end
    end

    logic in_req;
    assign in_req    = (state_q == REQ);
    assign stall     = in_req | ((state_q == IDLE) & req_any);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign bus_req   = in_req;
    assign bus_we    = in_req & lat_we;
    assign bus_addr  = in_req ? {lat_addr[31:2], 2'b00} : 32'd0;
    assign bus_be    = in_req ? lat_be : 4'd0;
    assign bus_wdata = in_req ? lat_wdata : 32'd0;
    assign state_dbg = state_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the single-cycle core datapath and a data-memory bus with a req/ack handshake.
- Takes the Load/Store size codes and memory-access strobes produced by the main decoder, together with the ALU-computed address and rs2 data.
- Drives the word-aligned bus with byte enables, stalls the core until completion, and returns sign- or zero-extended load data.
- Exactly one access is outstanding at a time.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles in REQ waiting for bus_ack before the access is aborted with err. Range 1..255; the counter is 8 bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_rd  in  1  load instruction present (decoder ResultSrc==01).
- mem_wr  in  1  store instruction present (decoder MemWrite).
- load_sz  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu; 101-111 illegal.
- store_sz  in  2  00 sb, 01 sh, 10 sw; 11 illegal.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  hold PC and register write-back.
- rdata  out  32  extended load result, registered.
- done  out  1  one-cycle pulse when the access completes.
- err  out  1  valid with done: misaligned, illegal size, or timeout.
- bus_req  out  1  memory request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-positioned store data.
- bus_ack  in  1  memory completes the request (one-cycle pulse).
- bus_rdata  in  32  read word, valid with bus_ack.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - All outputs 0, rdata=0, timeout counter=0.
  - An in-flight request is abandoned: bus_req is low from the next cycle, and no done is issued.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If mem_wr or mem_rd is high: stall=1 combinationally in the same cycle.
  - If both are high, the store wins; the load is ignored.
  - Access is legal: latch addr, size and wdata; go to REQ.
  - Access is misaligned or illegal: go to DONE with err=1, no bus activity, rdata unchanged.
  - Misaligned means: h-type with addr[0]=1, or w-type with addr[1:0]!=00.
- REQ:
  - bus_req=1, stall=1.
  - bus_addr, bus_we, bus_be and bus_wdata come from latched values and are stable until ack.
  - Counter increments each cycle.
  - On bus_ack, go to DONE; for loads, rdata is captured on that edge.
  - If the counter reaches TIMEOUT_CYC without ack: go to DONE, err=1, bus_req drops, rdata unchanged.
  - bus_ack while in IDLE or DONE is ignored.
- DONE:
  - done=1, stall=0 (the core advances on this edge).
  - err is held from the preceding transition.
  - Always returns to IDLE; mem_rd/mem_wr are ignored in this cycle.
  - Minimum access latency: IDLE->REQ->DONE, i.e. 3 cycles with ack on the first REQ cycle.
- Byte enables, with o = addr[1:0]:
  - sb: 4'b0001<<o.
  - sh: 4'b0011<<o.
  - sw: 4'b1111.
  - Loads: 4'b1111.
- Store data:
  - sb replicates wdata[7:0] into all 4 lanes.
  - sh replicates wdata[15:0] into both halves.
  - sw passes wdata through.
- Load extraction:
  - Select byte lane o or half-word lane o[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- rdata holds its value until the next successful load.
- err clears on the next IDLE->REQ or IDLE->DONE transition.

Test Plan:
- Aligned sw: addr=0x104, wdata=0xDEADBEEF, bus_ack on the 2nd REQ cycle -> bus_be=1111, bus_addr=0x104, bus_we=1, stall high for 3 cycles, done pulse, err=0.
- sb: addr=0x203, wdata=0x000000A5 -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x200.
- Loads at addr=0x302, bus_rdata=0x80F17F00:
  - lh -> rdata=0xFFFF80F1.
  - lhu -> rdata=0x000080F1.
  - lb -> rdata=0xFFFFFFF1.
  - lbu at addr 0x301 -> rdata=0x0000007F.
- Misaligned lw at addr=0x101 -> bus_req never asserted, done+err on the 2nd cycle, rdata unchanged.
- Timeout with TIMEOUT_CYC=4 and ack never asserted -> bus_req high for exactly 4 cycles, then done+err=1, stall released.
- reset=0 asserted during REQ -> bus_req=0 and stall=0 on the next cycle, no done; the next load completes normally.
